// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types: FSM state encoding, word width, NOP encoding, buffer entry.
// Build option FETCH_PREFETCH_EN selects a two-entry fetch buffer; without it the buffer holds one entry.
package pipeline_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;

`ifdef FETCH_PREFETCH_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] next_addr;
    } fetch_entry_t;

    // Word addresses wrap modulo 2^WORD_W.
    function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] addr);
        return addr + WORD_W'(1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order instruction buffer of DEPTH entries; head is the oldest entry.
// Push and pop in the same cycle are both honoured, including on a full buffer.
module fetch_buffer
    import pipeline_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WORD_W-1:0] push_instr,
    input  logic [WORD_W-1:0] push_next,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic [WORD_W-1:0] head_instr,
    output logic [WORD_W-1:0] head_next
);

    localparam int ENTRY_W = $bits(fetch_entry_t);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [DEPTH*ENTRY_W-1:0] store;
    logic [DEPTH*ENTRY_W-1:0] store_next;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_next;
    logic [CNT_W-1:0]         wr_idx;
    logic                     do_push;
    logic                     do_pop;
    fetch_entry_t             push_entry;
    fetch_entry_t             head;

    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count == CNT_W'(DEPTH - 1));
    assign empty       = (count == '0);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Slot 0 is the head; after a pop the entries shift down by one, so the write slot moves too.
    assign wr_idx  = do_pop ? (count - CNT_W'(1)) : count;

    assign push_entry.instr     = push_instr;
    assign push_entry.next_addr = push_next;

    always_comb begin
        store_next = store;
        count_next = count;
        if (do_pop) begin
            store_next = store >> ENTRY_W;
            count_next = count - CNT_W'(1);
        end
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    store_next[i*ENTRY_W +: ENTRY_W] = push_entry;
                end
            end
            count_next = count_next + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store <= '0;
            count <= '0;
        end else if (flush) begin
            store <= '0;
            count <= '0;
        end else begin
            store <= store_next;
            count <= count_next;
        end
    end

    assign head       = store[ENTRY_W-1:0];
    assign head_instr = head.instr;
    assign head_next  = head.next_addr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: memory request FSM and fetch PC, feeding a small instruction buffer.
// Buffer depth follows FETCH_PREFETCH_EN (2 entries when defined, otherwise 1).
//
// state | meaning
// IDLE  | first cycle after reset, no request
// REQ   | request outstanding at mem_addr; completed words are buffered
// FULL  | buffer full, no request until the head is consumed
// DRAIN | redirect pending; waiting out the old request, its data is dropped
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_ADDR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branched,
    input  logic [WORD_W-1:0] branch_target,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] next_address,
    output logic              inst_valid
);

    fetch_state_t      state;
    logic [WORD_W-1:0] fetch_pc;

    logic              buf_full;
    logic              buf_almost_full;
    logic              buf_empty;
    logic [WORD_W-1:0] head_instr;
    logic [WORD_W-1:0] head_next;

    logic              consume;
    logic              push;
    logic              fills;

    // A redirect overrides both stall and consumption: the whole buffer is discarded.
    assign consume = !buf_empty && !stall && !branched;
    assign push    = (state == REQ) && mem_ready && !branched && (!buf_full || consume);
    assign fills   = push && !consume && buf_almost_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_ADDR;
            mem_req  <= 1'b0;
            mem_addr <= RESET_ADDR;
        end else begin
            case (state)
                IDLE: begin
                    state   <= REQ;
                    mem_req <= 1'b1;
                    if (branched) begin
                        fetch_pc <= branch_target;
                        mem_addr <= branch_target;
                    end else begin
                        mem_addr <= fetch_pc;
                    end
                end

                REQ: begin
                    if (branched && mem_ready) begin
                        fetch_pc <= branch_target;
                        mem_addr <= branch_target;
                    end else if (branched) begin
                        // mem_req/mem_addr must stay put until the old request completes.
                        fetch_pc <= branch_target;
                        state    <= DRAIN;
                    end else if (mem_ready) begin
                        fetch_pc <= next_word(fetch_pc);
                        mem_addr <= next_word(fetch_pc);
                        if (fills) begin
                            state   <= FULL;
                            mem_req <= 1'b0;
                        end
                    end
                end

                FULL: begin
                    if (branched) begin
                        fetch_pc <= branch_target;
                        mem_addr <= branch_target;
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end else if (consume) begin
                        mem_addr <= fetch_pc;
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end

                DRAIN: begin
                    if (mem_ready) begin
                        state <= REQ;
                        if (branched) begin
                            fetch_pc <= branch_target;
                            mem_addr <= branch_target;
                        end else begin
                            mem_addr <= fetch_pc;
                        end
                    end else if (branched) begin
                        fetch_pc <= branch_target;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_buffer #(
        .DEPTH(FETCH_DEPTH)
    ) u_fetch_buffer (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (consume),
        .flush       (branched),
        .push_instr  (mem_rdata),
        .push_next   (next_word(mem_addr)),
        .full        (buf_full),
        .almost_full (buf_almost_full),
        .empty       (buf_empty),
        .head_instr  (head_instr),
        .head_next   (head_next)
    );

    assign inst_valid   = !buf_empty;
    assign instruction  = buf_empty ? NOP_INSTR : head_instr;
    assign next_address = buf_empty ? NOP_INSTR : head_next;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/full, redirects, address wrap, reset abandon.
// Expectations adapt to FETCH_PREFETCH_EN (buffer depth 2) when that macro is defined.
`timescale 1ns/1ps
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branched;
    logic [15:0] branch_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic [15:0] next_address;
    logic        inst_valid;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(
        .RESET_ADDR(16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branched      (branched),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .instruction   (instruction),
        .next_address  (next_address),
        .inst_valid    (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] dat(input logic [15:0] addr);
        return addr ^ 16'hA5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = dat(mem_addr);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        stall         = 1'b0;
        branched      = 1'b0;
        branch_target = 16'h0000;
        mem_ready     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 8) begin
            tick();
            n++;
        end
        check(tag, {31'd0, mem_req}, 32'd1);
    endtask

    initial begin
        logic [15:0] exp_i;
        logic [15:0] exp_f;
        int          cons;
        int          fets;

        rst           = 1'b1;
        stall         = 1'b0;
        branched      = 1'b0;
        branch_target = 16'h0000;
        mem_ready     = 1'b1;
        mem_rdata     = 16'h0000;
        tick();
        tick();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'h0000);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_instruction", {16'd0, instruction}, 32'h0000);
        check("rst_next_address", {16'd0, next_address}, 32'h0000);

        // Streaming with memory always ready.
        do_reset();
        mem_ready = 1'b1;
        check("idle_no_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", {16'd0, mem_addr}, 32'h0000);
        check("first_not_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("third_valid", {31'd0, inst_valid}, 32'd1);
        check("third_instr", {16'd0, instruction}, {16'd0, dat(16'h0000)});
        check("third_next", {16'd0, next_address}, 32'h0001);
        exp_i = 16'h0000;
        exp_f = 16'h0001;
        cons  = 0;
        fets  = 0;
        for (int c = 0; c < 16; c++) begin
            if (inst_valid) begin
                check("stream_instr", {16'd0, instruction}, {16'd0, dat(exp_i)});
                check("stream_next", {16'd0, next_address}, {16'd0, exp_i + 16'd1});
                exp_i = exp_i + 16'd1;
                cons++;
            end
            if (mem_req) begin
                check("stream_addr", {16'd0, mem_addr}, {16'd0, exp_f});
                exp_f = exp_f + 16'd1;
                fets++;
            end
            tick();
        end
        check("stream_consumes", cons, (DEPTH == 2) ? 32'd16 : 32'd8);
        check("stream_fetches", fets, (DEPTH == 2) ? 32'd16 : 32'd8);

        // Stall fills the buffer, then FULL drops the request.
        do_reset();
        mem_ready = 1'b1;
        stall     = 1'b1;
        fets      = 0;
        for (int c = 0; c < 6; c++) begin
            if (mem_req && mem_ready) fets++;
            tick();
        end
        check("stall_fetches", fets, DEPTH);
        check("stall_full_no_req", {31'd0, mem_req}, 32'd0);
        check("stall_valid", {31'd0, inst_valid}, 32'd1);
        check("stall_instr", {16'd0, instruction}, {16'd0, dat(16'h0000)});
        check("stall_next", {16'd0, next_address}, 32'h0001);
        stall = 1'b0;
        tick();
        check("unstall_req", {31'd0, mem_req}, 32'd1);
        check("unstall_addr", {16'd0, mem_addr}, DEPTH);
        check("unstall_valid", {31'd0, inst_valid}, (DEPTH == 2) ? 32'd1 : 32'd0);
        check("unstall_instr", {16'd0, instruction}, (DEPTH == 2) ? {16'd0, dat(16'h0001)} : 32'h0000);

        // Redirect from FULL while stalled: flush wins over stall.
        do_reset();
        mem_ready = 1'b1;
        stall     = 1'b1;
        repeat (4) tick();
        check("full_before_branch", {31'd0, mem_req}, 32'd0);
        branched      = 1'b1;
        branch_target = 16'h0200;
        tick();
        branched = 1'b0;
        check("full_branch_valid", {31'd0, inst_valid}, 32'd0);
        check("full_branch_instr", {16'd0, instruction}, 32'h0000);
        check("full_branch_next", {16'd0, next_address}, 32'h0000);
        check("full_branch_req", {31'd0, mem_req}, 32'd1);
        check("full_branch_addr", {16'd0, mem_addr}, 32'h0200);
        stall = 1'b0;
        tick();
        check("full_branch_data", {16'd0, instruction}, {16'd0, dat(16'h0200)});
        check("full_branch_dnext", {16'd0, next_address}, 32'h0201);

        // Redirect while a request waits: drain the old one, then fetch the target.
        do_reset();
        mem_ready = 1'b0;
        tick();
        branched      = 1'b1;
        branch_target = 16'h0040;
        tick();
        branched = 1'b0;
        check("drain_req", {31'd0, mem_req}, 32'd1);
        check("drain_addr", {16'd0, mem_addr}, 32'h0000);
        check("drain_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        tick();
        check("drain_hold_req", {31'd0, mem_req}, 32'd1);
        check("drain_hold_addr", {16'd0, mem_addr}, 32'h0000);
        mem_ready = 1'b1;
        tick();
        check("redirect_req", {31'd0, mem_req}, 32'd1);
        check("redirect_addr", {16'd0, mem_addr}, 32'h0040);
        check("redirect_no_stale", {31'd0, inst_valid}, 32'd0);
        tick();
        check("redirect_valid", {31'd0, inst_valid}, 32'd1);
        check("redirect_instr", {16'd0, instruction}, {16'd0, dat(16'h0040)});
        check("redirect_next", {16'd0, next_address}, 32'h0041);

        // A second redirect during DRAIN replaces the target.
        do_reset();
        mem_ready = 1'b0;
        tick();
        branched      = 1'b1;
        branch_target = 16'h0010;
        tick();
        branch_target = 16'h0020;
        tick();
        branched = 1'b0;
        check("drain2_hold_addr", {16'd0, mem_addr}, 32'h0000);
        mem_ready = 1'b1;
        tick();
        check("drain2_redirect", {16'd0, mem_addr}, 32'h0020);

        // Redirect and completion in the same cycle: the completed word is dropped.
        do_reset();
        mem_ready = 1'b1;
        tick();
        branched      = 1'b1;
        branch_target = 16'h0100;
        tick();
        branched = 1'b0;
        check("bm_req", {31'd0, mem_req}, 32'd1);
        check("bm_addr", {16'd0, mem_addr}, 32'h0100);
        check("bm_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("bm_instr", {16'd0, instruction}, {16'd0, dat(16'h0100)});
        check("bm_next", {16'd0, next_address}, 32'h0101);

        // Address wrap at 16'hFFFF.
        do_reset();
        mem_ready = 1'b1;
        tick();
        branched      = 1'b1;
        branch_target = 16'hFFFF;
        tick();
        branched = 1'b0;
        check("wrap_addr", {16'd0, mem_addr}, 32'hFFFF);
        tick();
        check("wrap_instr", {16'd0, instruction}, {16'd0, dat(16'hFFFF)});
        check("wrap_next", {16'd0, next_address}, 32'h0000);
        wait_req("wrap_wait_req");
        check("wrap_follow_addr", {16'd0, mem_addr}, 32'h0000);

        // Reset in the middle of an outstanding request.
        do_reset();
        mem_ready = 1'b1;
        tick();
        branched      = 1'b1;
        branch_target = 16'h0030;
        tick();
        branched  = 1'b0;
        mem_ready = 1'b0;
        check("pre_rst_addr", {16'd0, mem_addr}, 32'h0030);
        rst = 1'b1;
        #1;
        check("async_rst_req", {31'd0, mem_req}, 32'd0);
        check("async_rst_addr", {16'd0, mem_addr}, 32'h0000);
        check("async_rst_valid", {31'd0, inst_valid}, 32'd0);
        mem_ready = 1'b1;
        tick();
        rst = 1'b0;
        check("rel_no_req", {31'd0, mem_req}, 32'd0);
        check("rel_not_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("rel_first_req", {31'd0, mem_req}, 32'd1);
        check("rel_first_addr", {16'd0, mem_addr}, 32'h0000);
        check("rel_still_empty", {31'd0, inst_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
